ifetch_unit: RTL and testbench

//   Instruction fetch stage downstream of the PC unit. Takes the current PC and issues word reads to

---
 rtl/ifetch_unit_pkg.sv | 11 +
 rtl/ifetch_fifo.sv | 47 ++++
 rtl/ifetch_unit.sv | 85 ++++++++
 tb/tb_ifetch_unit.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/ifetch_unit_pkg.sv
// ifetch_unit_pkg: fetch FSM states, buffer entry layout and PC helper shared by the fetch stage.
package ifetch_unit_pkg;
   typedef enum logic [1:0] {IFU_IDLE, IFU_REQ, IFU_FLUSH} ifu_state_t;
   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
   } fetch_entry_t;
   function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
      return pc + 32'd4;
   endfunction
endpackage

// File: rtl/ifetch_fifo.sv
// ifetch_fifo: synchronous {instr, pc} buffer with push, pop and a clear that overrides push.
module ifetch_fifo
   import ifetch_unit_pkg::*;
#(
   parameter int DEPTH = 2,
   localparam int AW = $clog2(DEPTH),
   localparam int CW = AW + 1
) (
   input  logic         CLK,
   input  logic         RST,
   input  logic         push,
   input  logic         pop,
   input  logic         clear,
   input  fetch_entry_t din,
   output logic [CW-1:0] count,
   output logic         empty,
   output logic         full,
   output fetch_entry_t head
);
   fetch_entry_t mem [DEPTH];
   logic [AW-1:0] wptr, rptr;
   logic wr, rd;
   assign empty = count == '0;
   assign full = count == CW'(DEPTH);
   assign rd = pop & ~empty;
   // a pop frees the head slot this edge, so a full buffer can still accept a push
   assign wr = push & (~full | rd);
   assign head = empty ? '0 : mem[rptr];
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         wptr <= '0;
         rptr <= '0;
         count <= '0;
      end else if (clear) begin
         wptr <= '0;
         rptr <= '0;
         count <= '0;
      end else begin
         wptr <= wr ? wptr + AW'(1) : wptr;
         rptr <= rd ? rptr + AW'(1) : rptr;
         count <= count + CW'(wr) - CW'(rd);
      end
   end
   always_ff @(posedge CLK) begin
      if (wr & ~clear) mem[wptr] <= din;
   end
endmodule

// File: rtl/ifetch_unit.sv
// ifetch_unit: fetch stage pairing imem words with their PC for decode.
// IFETCH_PERF_EN adds fetch/stall/flush counters; otherwise perf_* read 0.
module ifetch_unit
   import ifetch_unit_pkg::*;
#(
   parameter int FIFO_DEPTH = 2,
   parameter int ADDR_W = 32
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic [31:0]       pc_in,
   output logic              pc_en,
   input  logic              redirect,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_ack,
   input  logic [31:0]       imem_rdata,
   output logic              id_valid,
   input  logic              id_ready,
   output logic [31:0]       id_instr,
   output logic [31:0]       id_pc,
   output logic [31:0]       id_pc4,
   output logic [31:0]       perf_fetch,
   output logic [31:0]       perf_stall,
   output logic [31:0]       perf_flush
);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   ifu_state_t state;
   logic [CW-1:0] count;
   logic empty, full, push, pop, clear;
   logic [ADDR_W-1:0] pc_addr, flush_addr;
   fetch_entry_t head;
   assign pc_addr = {pc_in[ADDR_W-1:2], 2'b00};
   assign imem_req = state == IFU_FLUSH || (state == IFU_REQ && count < CW'(FIFO_DEPTH));
   // the abandoned request keeps its address while the PC already holds the target
   assign imem_addr = state == IFU_FLUSH ? flush_addr : pc_addr;
   assign clear = redirect && state != IFU_IDLE;
   assign push = state == IFU_REQ && imem_req && imem_ack && !redirect;
   assign pop = !empty && id_ready;
   assign pc_en = push || clear;
   assign id_valid = !empty;
   assign id_instr = head.instr;
   assign id_pc = head.pc;
   assign id_pc4 = empty ? '0 : pc_plus4(head.pc);
   ifetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .CLK  (CLK),
      .RST  (RST),
      .push (push),
      .pop  (pop),
      .clear(clear),
      .din  ('{instr: imem_rdata, pc: pc_in}),
      .count(count),
      .empty(empty),
      .full (full),
      .head (head)
   );
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state <= IFU_IDLE;
         flush_addr <= '0;
      end else begin
         state <= state == IFU_IDLE ? IFU_REQ :
                  (state == IFU_REQ && redirect && !full && !imem_ack) ? IFU_FLUSH :
                  (state == IFU_FLUSH && imem_ack) ? IFU_REQ : state;
         flush_addr <= state == IFU_REQ ? pc_addr : flush_addr;
      end
   end
`ifdef IFETCH_PERF_EN
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         perf_fetch <= '0;
         perf_stall <= '0;
         perf_flush <= '0;
      end else begin
         perf_fetch <= perf_fetch + 32'(push);
         perf_stall <= perf_stall + 32'(state == IFU_REQ && full);
         perf_flush <= perf_flush + 32'(clear);
      end
   end
`else
   assign perf_fetch = '0;
   assign perf_stall = '0;
   assign perf_flush = '0;
`endif
endmodule

// File: tb/tb_ifetch_unit.sv
// tb_ifetch_unit: random fetch traffic against a queue-based model of the fetch buffer and PC unit.
module tb_ifetch_unit;
   localparam int DEPTH = 2;
   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
   } exp_t;
   logic CLK = 0;
   logic RST = 0;
   logic [31:0] pc_in, imem_addr, imem_rdata, id_instr, id_pc, id_pc4;
   logic [31:0] perf_fetch, perf_stall, perf_flush;
   logic pc_en, redirect, imem_req, imem_ack, id_valid, id_ready;
   exp_t exp_q[$];
   int errors = 0, checks = 0;
   logic [31:0] pc, target;
   bit discard, busy, pushed_now;
   int lat, lat_min, lat_max, ready_pct, redir_pct;
   bit redir_on_ack;
   logic [31:0] m_fetch, m_stall, m_flush;

   ifetch_unit #(.FIFO_DEPTH(DEPTH), .ADDR_W(32)) dut (
      .CLK(CLK), .RST(RST), .pc_in(pc_in), .pc_en(pc_en), .redirect(redirect),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr), .id_pc(id_pc), .id_pc4(id_pc4),
      .perf_fetch(perf_fetch), .perf_stall(perf_stall), .perf_flush(perf_flush)
   );

   always #5 CLK = ~CLK;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
   endfunction

   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h want %h at %0t", n, act, exp, $time);
      end
   endtask

   task automatic check_perf();
`ifdef IFETCH_PERF_EN
      chk("perf_fetch", perf_fetch, m_fetch);
      chk("perf_stall", perf_stall, m_stall);
      chk("perf_flush", perf_flush, m_flush);
`else
      chk("perf_tied", perf_fetch | perf_stall | perf_flush, 32'h0);
`endif
   endtask

   task automatic knobs(input int lmin, input int lmax, input int rp, input int dp, input bit roa);
      lat_min = lmin;
      lat_max = lmax;
      ready_pct = rp;
      redir_pct = dp;
      redir_on_ack = roa;
   endtask

   task automatic do_reset(input bit mid);
      if (mid) begin
         @(posedge CLK);
         #1;
         pc_in = pc;
         imem_ack = 0;
         redirect = 0;
         #1;
         chk("req_before_rst", imem_req, 1);
      end
      RST = 1;
      #1;
      chk("rst_req", imem_req, 0);
      chk("rst_valid", id_valid, 0);
      chk("rst_pc_en", pc_en, 0);
      chk("rst_id", id_instr | id_pc | id_pc4, 0);
      exp_q.delete();
      discard = 0;
      busy = 0;
      pushed_now = 0;
      m_fetch = 0;
      m_stall = 0;
      m_flush = 0;
      pc = 32'h3000;
      repeat (2) @(posedge CLK);
      #1;
      RST = 0;
      pc_in = pc;
      imem_ack = 0;
      redirect = 0;
      #1;
      chk("idle_req", imem_req, 0);
      check_perf();
   endtask

   // one clock of stimulus; the model predicts req, addr and pc_en and queues accepted fetches
   task automatic step();
      int occ;
      bit acc;
      @(posedge CLK);
      #1;
      check_perf();
      pc_in = pc;
      imem_ack = 0;
      redirect = 0;
      id_ready = $urandom_range(99) < ready_pct;
      #1;
      occ = exp_q.size();
      chk("imem_req", imem_req, discard || occ < DEPTH);
      if (imem_req && !discard) chk("imem_addr", imem_addr, {pc[31:2], 2'b00});
      if (imem_req) begin
         if (!busy) begin
            busy = 1;
            lat = $urandom_range(lat_max, lat_min);
         end
         if (lat == 0) begin
            imem_ack = 1;
            imem_rdata = mem_word(imem_addr);
            busy = 0;
         end else lat--;
      end
      redirect = (redir_on_ack && imem_ack && occ == DEPTH - 1) || $urandom_range(99) < redir_pct;
      case ($urandom_range(3))
         0: target = 32'hFFFF_FFF8;
         1: target = 32'h0000_3002;
         default: target = $urandom() & 32'hFFFF_FFFC;
      endcase
      #1;
      acc = imem_req && imem_ack && !redirect && !discard;
      chk("pc_en", pc_en, acc || redirect);
      if (acc) begin
         exp_q.push_back('{instr: mem_word({pc[31:2], 2'b00}), pc: pc});
         pushed_now = 1;
         m_fetch++;
      end
      if (redirect) m_flush++;
      if (!discard && occ == DEPTH) m_stall++;
      discard = imem_req && !imem_ack && (discard || redirect);
      pc = redirect ? target : acc ? pc + 32'd4 : pc;
   endtask

   always @(negedge CLK) begin
      exp_t e;
      if (!RST) begin
         chk("id_valid", id_valid, exp_q.size() > int'(pushed_now));
         if (id_valid && id_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL pop_empty: got an instruction pc=%h want none", id_pc);
            end else begin
               e = exp_q.pop_front();
               chk("id_instr", id_instr, e.instr);
               chk("id_pc", id_pc, e.pc);
               chk("id_pc4", id_pc4, e.pc + 32'd4);
            end
         end else if (!id_valid) chk("id_empty_zero", id_instr | id_pc | id_pc4, 0);
         if (redirect) exp_q.delete();
         pushed_now = 0;
      end
   end

   initial begin
      pc = 32'h3000;
      pc_in = pc;
      imem_ack = 0;
      imem_rdata = 0;
      redirect = 0;
      id_ready = 0;
      knobs(0, 0, 100, 0, 0);
      #2;
      do_reset(0);
      repeat (20) step();
      knobs(0, 0, 0, 0, 0);
      repeat (8) step();
      knobs(0, 0, 100, 0, 0);
      repeat (8) step();
      knobs(3, 3, 100, 15, 0);
      repeat (40) step();
      knobs(0, 0, 40, 0, 1);
      repeat (40) step();
      knobs(0, 3, 70, 10, 1);
      repeat (400) step();
      knobs(3, 3, 100, 0, 0);
      repeat (5) step();
      do_reset(1);
      knobs(0, 2, 60, 10, 0);
      repeat (100) step();
      knobs(0, 0, 100, 0, 0);
      repeat (10) step();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
